i_mshr_ooo: RTL and testbench
=============================

Name: i_mshr_ooo

Overview:
- Parametrised successor to the FIFO-ordered instruction MSHR.
- Fully associative table of outstanding I-cache line requests. Memory responses are matched out of order by mem tag, not only at the head.
- Supports a squash on redirect: in-flight prefetches are dropped instead of polluting the cache.
- Sits between the prefetcher/arbiter (allocation, snooping) and the icache write port (fill).

Parameters:
- NUM_ENTRIES, default `NUM_MEM_TAGS: number of MSHR entries (any value >= 2, not required to be a power of 2).
- ITAG_W, default `ITAG_BITS: width of the icache line tag.
- MTAG_W, default $bits(MEM_TAG): width of the memory tag. Tag value 0 means "no tag".
- DROP_SQUASHED, default 1: 1 = squashed entries suppress their fill; 0 = squash is ignored and every response fills.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  memory request accepted this cycle; record it
- alloc_itag  in  ITAG_W  line tag of the accepted request
- alloc_mem_tag  in  MTAG_W  memory tag returned by mem for the request
- alloc_ready  out  1  at least one FREE entry
- snoop_valid  in  1  prefetcher lookup strobe
- snoop_itag  in  ITAG_W  line tag to look up
- snoop_hit  out  1  a PENDING entry holds snoop_itag
- mem_data_tag  in  MTAG_W  tag of the response on the memory bus this cycle
- squash  in  1  redirect: drop all currently outstanding requests
- fill_valid  out  1  write the response data into the icache this cycle
- fill_itag  out  ITAG_W  line tag for the icache write
- count  out  $clog2(NUM_ENTRIES+1)  number of non-FREE entries

Behaviour:

Entry state and reset:
- Each entry holds: state in {FREE, PENDING, SQUASHED}, itag, mem_tag.
- Reset: all entries FREE with zeroed fields.
- Outputs during and after reset: alloc_ready=1, snoop_hit=0, fill_valid=0, fill_itag=0, count=0.
- Reset mid-operation discards all entries. Responses arriving in the reset cycle are ignored.

Allocate:
- Fires when alloc_valid & alloc_ready & alloc_mem_tag!=0.
- The lowest-index FREE entry (from registered state) becomes PENDING at the next edge.
- alloc_valid with alloc_mem_tag==0, or with alloc_ready=0, is ignored (no state change).
- alloc_ready is computed from registered state only. An entry freed this cycle cannot be reused in the same cycle.

Response (combinational, same cycle as mem_data_tag, so it aligns with mem_data):
- If mem_data_tag!=0 matches the mem_tag of an entry in PENDING state: fill_valid=1 and fill_itag=entry.itag. The entry becomes FREE at the next edge.
- If it matches a SQUASHED entry: fill_valid=0, and the entry becomes FREE at the next edge.
- No match: no effect, fill_valid=0.
- Multiple matches violate the mem-tag uniqueness invariant. The lowest index wins; a verification assertion flags it.

Squash:
- At the next edge, every entry that is PENDING and not filling this cycle becomes SQUASHED.
- A response in the squash cycle still fills, because it uses current state.
- An allocation in the squash cycle enters as PENDING: it is treated as a post-redirect request.
- With DROP_SQUASHED=0, squash has no effect.

Snoop:
- snoop_hit = snoop_valid & OR over entries of (state==PENDING & itag==snoop_itag).
- SQUASHED entries never hit, so a refetch after a redirect re-requests the line.
- An entry filling this cycle still hits; the icache holds the line from the next cycle.
- Same-cycle allocations are not visible to snoop.

count:
- Registered population count of non-FREE entries.
- Next-cycle count = count + alloc_accepted - response_match.

Simultaneous alloc and response:
- Both take effect.
- When full, a response does not enable an allocation until the following cycle.

Decomposition:
- Shared package (sys_defs.svh): enum MSHR_STATE {MSHR_FREE, MSHR_PENDING, MSHR_SQUASHED}; struct MSHR_ENTRY {state, itag, mem_tag}.
- Free-slot selection reuses the existing psel_gen (REQS=1) over the FREE bitmap.
- One natural sub-module: i_mshr_entry, a per-entry state register with match/next-state logic, instantiated NUM_ENTRIES times. The top level does selection, OR-reduction of hit/fill, and count.

Test Plan:
1. Reset, then alloc (itag=0x1A, mtag=3) -> next cycle count=1, snoop 0x1A hit=1. mem_data_tag=3 -> fill_valid=1, fill_itag=0x1A the same cycle; count=0 next cycle.
2. Out-of-order return: alloc tags 1,2,3 (itags A,B,C). Return order 3,1,2 -> fills C, A, B, each in its response cycle; count goes 3,2,1,0.
3. Full (NUM_ENTRIES=4): four allocs -> alloc_ready=0. A 5th alloc is ignored. Response plus alloc in the same cycle -> the alloc is dropped and alloc_ready=1 the next cycle.
4. Squash with tags 5 (itag D) and 6 (itag E) outstanding, plus a same-cycle alloc of tag 7 (itag F) -> snoop D hit=0. Return 5 gives fill_valid=0 and count decrements. Return 7 gives fill_valid=1, fill_itag=F.
5. Squash in the same cycle as return of tag 5 -> fill_valid=1 for that entry; the other entries become SQUASHED.
6. Reset asserted with 3 entries PENDING -> count=0, alloc_ready=1 next cycle. A later response with an old tag -> fill_valid=0.

Source files
------------

// File: rtl/i_mshr_ooo_pkg.sv
// i_mshr_ooo_pkg
// Shared types and default sizes for the out-of-order instruction MSHR.
// Contents:
//   NUM_MEM_TAGS - default number of MSHR entries (one per memory tag in flight)
//   ITAG_BITS    - default icache line-tag width
//   MEM_TAG      - memory tag type; the value 0 means "no tag"
//   MSHR_STATE   - per-entry lifecycle: FREE -> PENDING -> (SQUASHED) -> FREE
//   MSHR_ENTRY   - one table entry at the default widths
package i_mshr_ooo_pkg;

  localparam int NUM_MEM_TAGS = 4;
  localparam int ITAG_BITS    = 8;
  localparam int MEM_TAG_BITS = 4;

  typedef logic [MEM_TAG_BITS-1:0] MEM_TAG;

  typedef enum logic [1:0] {
    MSHR_FREE     = 2'd0,
    MSHR_PENDING  = 2'd1,
    MSHR_SQUASHED = 2'd2
  } MSHR_STATE;

  typedef struct packed {
    MSHR_STATE            state;
    logic [ITAG_BITS-1:0] itag;
    MEM_TAG               mem_tag;
  } MSHR_ENTRY;

endpackage

// File: rtl/i_mshr_ooo_entry.sv
// i_mshr_ooo_entry
// One MSHR table entry: state register plus tag match and next-state logic.
// Ports:
//   clock, reset       - clock, synchronous active-high reset
//   allocEn_i          - this entry was chosen for the accepted allocation
//   allocItag_i        - line tag to record on allocation
//   allocMtag_i        - memory tag to record on allocation
//   memDataTag_i       - tag of the memory response this cycle
//   respGrant_i        - this entry won the response match; free it
//   squash_i           - redirect: PENDING entries become SQUASHED
//   snoopItag_i        - line tag being looked up
//   free_o             - entry is FREE
//   respMatch_o        - response tag matches this (non-FREE) entry
//   fillMatch_o        - response matches and the entry is PENDING
//   snoopHit_o         - entry is PENDING and holds snoopItag_i
//   itag_o             - recorded line tag
module i_mshr_ooo_entry
  import i_mshr_ooo_pkg::*;
#(
  parameter int ITAG_W        = ITAG_BITS,
  parameter int MTAG_W        = $bits(MEM_TAG),
  parameter int DROP_SQUASHED = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              allocEn_i,
  input  logic [ITAG_W-1:0] allocItag_i,
  input  logic [MTAG_W-1:0] allocMtag_i,
  input  logic [MTAG_W-1:0] memDataTag_i,
  input  logic              respGrant_i,
  input  logic              squash_i,
  input  logic [ITAG_W-1:0] snoopItag_i,
  output logic              free_o,
  output logic              respMatch_o,
  output logic              fillMatch_o,
  output logic              snoopHit_o,
  output logic [ITAG_W-1:0] itag_o
);

  MSHR_STATE         state_q, state_d;
  logic [ITAG_W-1:0] itag_q, itag_d;
  logic [MTAG_W-1:0] mtag_q, mtag_d;

  // Tag 0 is never a real request, so it must not match a FREE entry's zeroed tag.
  assign free_o      = (state_q == MSHR_FREE);
  assign respMatch_o = (memDataTag_i != '0) && (mtag_q == memDataTag_i) && (state_q != MSHR_FREE);
  assign fillMatch_o = respMatch_o && (state_q == MSHR_PENDING);
  assign snoopHit_o  = (state_q == MSHR_PENDING) && (itag_q == snoopItag_i);
  assign itag_o      = itag_q;

  // Allocation only targets FREE entries and a grant only targets non-FREE
  // ones, so they never collide. A granted entry frees even during a squash.
  always_comb begin
    state_d = state_q;
    itag_d  = itag_q;
    mtag_d  = mtag_q;
    if (allocEn_i) begin
      state_d = MSHR_PENDING;
      itag_d  = allocItag_i;
      mtag_d  = allocMtag_i;
    end else if (respGrant_i) begin
      state_d = MSHR_FREE;
      itag_d  = '0;
      mtag_d  = '0;
    end else if (squash_i && (DROP_SQUASHED != 0) && (state_q == MSHR_PENDING)) begin
      state_d = MSHR_SQUASHED;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MSHR_FREE;
      itag_q  <= '0;
      mtag_q  <= '0;
    end else begin
      state_q <= state_d;
      itag_q  <= itag_d;
      mtag_q  <= mtag_d;
    end
  end

endmodule

// File: rtl/i_mshr_ooo.sv
// i_mshr_ooo
// Fully associative instruction MSHR. Responses are matched by memory tag in
// any order; a redirect squash marks outstanding prefetches so their data is
// dropped instead of filling the icache.
// Ports:
//   clock, reset   - clock, synchronous active-high reset
//   alloc_valid    - memory request accepted this cycle
//   alloc_itag     - line tag of that request
//   alloc_mem_tag  - memory tag assigned to it (0 = none, ignored)
//   alloc_ready    - at least one FREE entry (registered state only)
//   snoop_valid    - prefetcher lookup strobe
//   snoop_itag     - line tag to look up
//   snoop_hit      - a PENDING entry holds snoop_itag
//   mem_data_tag   - tag of the memory response this cycle
//   squash         - redirect: drop all outstanding requests
//   fill_valid     - write response data into the icache this cycle
//   fill_itag      - line tag for that write
//   count          - number of non-FREE entries
module i_mshr_ooo
  import i_mshr_ooo_pkg::*;
#(
  parameter int NUM_ENTRIES   = NUM_MEM_TAGS,
  parameter int ITAG_W        = ITAG_BITS,
  parameter int MTAG_W        = $bits(MEM_TAG),
  parameter int DROP_SQUASHED = 1,
  localparam int CNT_W        = $clog2(NUM_ENTRIES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [ITAG_W-1:0] alloc_itag,
  input  logic [MTAG_W-1:0] alloc_mem_tag,
  output logic              alloc_ready,
  input  logic              snoop_valid,
  input  logic [ITAG_W-1:0] snoop_itag,
  output logic              snoop_hit,
  input  logic [MTAG_W-1:0] mem_data_tag,
  input  logic              squash,
  output logic              fill_valid,
  output logic [ITAG_W-1:0] fill_itag,
  output logic [CNT_W-1:0]  count
);

  logic [NUM_ENTRIES-1:0] freeVec;
  logic [NUM_ENTRIES-1:0] matchVec;
  logic [NUM_ENTRIES-1:0] fillMatchVec;
  logic [NUM_ENTRIES-1:0] snoopVec;
  logic [NUM_ENTRIES-1:0] allocSel;
  logic [NUM_ENTRIES-1:0] respGrant;
  logic [ITAG_W-1:0]      itagArr [NUM_ENTRIES];
  logic [ITAG_W-1:0]      fillItag;
  logic                   allocAccept;
  logic                   respAny;
  logic [CNT_W-1:0]       count_q, count_d;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : gEntry
    i_mshr_ooo_entry #(
      .ITAG_W        (ITAG_W),
      .MTAG_W        (MTAG_W),
      .DROP_SQUASHED (DROP_SQUASHED)
    ) uEntry (
      .clock        (clock),
      .reset        (reset),
      .allocEn_i    (allocSel[g] & allocAccept),
      .allocItag_i  (alloc_itag),
      .allocMtag_i  (alloc_mem_tag),
      .memDataTag_i (mem_data_tag),
      .respGrant_i  (respGrant[g]),
      .squash_i     (squash),
      .snoopItag_i  (snoop_itag),
      .free_o       (freeVec[g]),
      .respMatch_o  (matchVec[g]),
      .fillMatch_o  (fillMatchVec[g]),
      .snoopHit_o   (snoopVec[g]),
      .itag_o       (itagArr[g])
    );
  end

  // Readiness depends only on registered state, so a slot freed by this
  // cycle's response is not reusable until next cycle.
  assign alloc_ready = reset | (|freeVec);
  assign allocAccept = ~reset & alloc_valid & (|freeVec) & (alloc_mem_tag != '0);

  // Lowest-index FREE entry takes the allocation; lowest-index match takes the
  // response, which only matters if the tag-uniqueness invariant is broken.
  always_comb begin
    allocSel  = '0;
    respGrant = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (freeVec[i]) begin
        allocSel    = '0;
        allocSel[i] = 1'b1;
      end
      if (matchVec[i] && !reset) begin
        respGrant    = '0;
        respGrant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    fillItag = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (respGrant[i] && fillMatchVec[i]) begin
        fillItag = fillItag | itagArr[i];
      end
    end
  end

  assign respAny    = |respGrant;
  assign fill_valid = |(respGrant & fillMatchVec);
  assign fill_itag  = fillItag;
  assign snoop_hit  = ~reset & snoop_valid & (|snoopVec);
  assign count      = reset ? '0 : count_q;

  assign count_d = count_q + CNT_W'(allocAccept) - CNT_W'(respAny);

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Two entries sharing a live memory tag means the requester reused a tag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ($onehot0(matchVec));
    end
  end

endmodule

// File: tb/tb_i_mshr_ooo.sv
// tb_i_mshr_ooo
// Directed, table-driven bench for the out-of-order instruction MSHR with four
// entries. Each vector drives one cycle of inputs and lists the outputs
// expected in that same cycle (count reflects state before the coming edge).
module tb_i_mshr_ooo;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int MW = 4;
  localparam int CW = 3;

  typedef struct {
    logic          rst;
    logic          av;
    logic [IW-1:0] ai;
    logic [MW-1:0] am;
    logic          sv;
    logic [IW-1:0] si;
    logic [MW-1:0] mt;
    logic          sq;
    logic          eReady;
    logic          eHit;
    logic          eFill;
    logic [IW-1:0] eItag;
    logic [CW-1:0] eCount;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          alloc_valid;
  logic [IW-1:0] alloc_itag;
  logic [MW-1:0] alloc_mem_tag;
  logic          alloc_ready;
  logic          snoop_valid;
  logic [IW-1:0] snoop_itag;
  logic          snoop_hit;
  logic [MW-1:0] mem_data_tag;
  logic          squash;
  logic          fill_valid;
  logic [IW-1:0] fill_itag;
  logic [CW-1:0] count;

  int checkCount = 0;
  int passCount  = 0;

  vec_t tbl[$];

  i_mshr_ooo #(
    .NUM_ENTRIES   (N),
    .ITAG_W        (IW),
    .MTAG_W        (MW),
    .DROP_SQUASHED (1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .alloc_valid   (alloc_valid),
    .alloc_itag    (alloc_itag),
    .alloc_mem_tag (alloc_mem_tag),
    .alloc_ready   (alloc_ready),
    .snoop_valid   (snoop_valid),
    .snoop_itag    (snoop_itag),
    .snoop_hit     (snoop_hit),
    .mem_data_tag  (mem_data_tag),
    .squash        (squash),
    .fill_valid    (fill_valid),
    .fill_itag     (fill_itag),
    .count         (count)
  );

  always #5 clock = ~clock;

  function automatic vec_t mkVec(
    input logic rst, input logic av, input logic [IW-1:0] ai, input logic [MW-1:0] am,
    input logic sv, input logic [IW-1:0] si, input logic [MW-1:0] mt, input logic sq,
    input logic eReady, input logic eHit, input logic eFill, input logic [IW-1:0] eItag,
    input logic [CW-1:0] eCount);
    vec_t v;
    v.rst = rst; v.av = av; v.ai = ai; v.am = am; v.sv = sv; v.si = si;
    v.mt = mt; v.sq = sq; v.eReady = eReady; v.eHit = eHit; v.eFill = eFill;
    v.eItag = eItag; v.eCount = eCount;
    return v;
  endfunction

  task automatic checkOne(input string name, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    reset         = v.rst;
    alloc_valid   = v.av;
    alloc_itag    = v.ai;
    alloc_mem_tag = v.am;
    snoop_valid   = v.sv;
    snoop_itag    = v.si;
    mem_data_tag  = v.mt;
    squash        = v.sq;
  endtask

  // Sample mid-cycle, well clear of the rising edge.
  task automatic checkOutput(input string tag, input vec_t v);
    #2;
    checkOne({tag, " alloc_ready"}, IW'(alloc_ready), IW'(v.eReady));
    checkOne({tag, " snoop_hit"},   IW'(snoop_hit),   IW'(v.eHit));
    checkOne({tag, " fill_valid"},  IW'(fill_valid),  IW'(v.eFill));
    checkOne({tag, " fill_itag"},   fill_itag,        v.eItag);
    checkOne({tag, " count"},       IW'(count),       IW'(v.eCount));
  endtask

  initial begin
    reset = 1'b1; alloc_valid = 1'b0; alloc_itag = '0; alloc_mem_tag = '0;
    snoop_valid = 1'b0; snoop_itag = '0; mem_data_tag = '0; squash = 1'b0;

    //                rst av ai     am sv si     mt sq  rdy hit fil itag   cnt
    // reset
    tbl.push_back(mkVec(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 0));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 0));
    // single alloc, snoop, fill
    tbl.push_back(mkVec(0, 1, 8'h1A, 3, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 0));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h1A, 0, 0,  1,  1,  0, 8'h00, 1));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h1A, 3, 0,  1,  1,  1, 8'h1A, 1));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h1A, 0, 0,  1,  0,  0, 8'h00, 0));
    // out-of-order return 3,1,2
    tbl.push_back(mkVec(0, 1, 8'h0A, 1, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 0));
    tbl.push_back(mkVec(0, 1, 8'h0B, 2, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 1));
    tbl.push_back(mkVec(0, 1, 8'h0C, 3, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 2));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 3, 0,  1,  0,  1, 8'h0C, 3));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 1, 0,  1,  0,  1, 8'h0A, 2));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 2, 0,  1,  0,  1, 8'h0B, 1));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 0));
    // fill to full, 5th alloc ignored, response + alloc while full
    tbl.push_back(mkVec(0, 1, 8'h10, 1, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 0));
    tbl.push_back(mkVec(0, 1, 8'h11, 2, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 1));
    tbl.push_back(mkVec(0, 1, 8'h12, 3, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 2));
    tbl.push_back(mkVec(0, 1, 8'h13, 4, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 3));
    tbl.push_back(mkVec(0, 1, 8'h14, 5, 0, 8'h00, 0, 0,  0,  0,  0, 8'h00, 4));
    tbl.push_back(mkVec(0, 1, 8'h15, 6, 0, 8'h00, 2, 0,  0,  0,  1, 8'h11, 4));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h15, 0, 0,  1,  0,  0, 8'h00, 3));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h14, 1, 0,  1,  0,  1, 8'h10, 3));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 3, 0,  1,  0,  1, 8'h12, 2));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 4, 0,  1,  0,  1, 8'h13, 1));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 0));
    // squash with D,E outstanding plus same-cycle alloc of F
    tbl.push_back(mkVec(0, 1, 8'h0D, 5, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 0));
    tbl.push_back(mkVec(0, 1, 8'h0E, 6, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 1));
    tbl.push_back(mkVec(0, 1, 8'h0F, 7, 1, 8'h0D, 0, 1,  1,  1,  0, 8'h00, 2));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h0D, 0, 0,  1,  0,  0, 8'h00, 3));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h0F, 0, 0,  1,  1,  0, 8'h00, 3));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 5, 0,  1,  0,  0, 8'h00, 3));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 7, 0,  1,  0,  1, 8'h0F, 2));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h0E, 6, 0,  1,  0,  0, 8'h00, 1));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 0));
    // alloc with mem tag 0 is ignored
    tbl.push_back(mkVec(0, 1, 8'h20, 0, 0, 8'h00, 0, 0,  1,  0,  0, 8'h00, 0));
    tbl.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h20, 0, 0,  1,  0,  0, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("row%0d", i), tbl[i]);
    end

    // Squash in the same cycle as a response: that response still fills.
    applyStimulus(mkVec(0, 1, 8'h25, 5, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
    checkOutput("sqfill0", mkVec(0, 1, 8'h25, 5, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
    applyStimulus(mkVec(0, 1, 8'h26, 6, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
    checkOutput("sqfill1", mkVec(0, 1, 8'h26, 6, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
    applyStimulus(mkVec(0, 0, 8'h00, 0, 1, 8'h26, 5, 1, 1, 1, 1, 8'h25, 2));
    checkOutput("sqfill2", mkVec(0, 0, 8'h00, 0, 1, 8'h26, 5, 1, 1, 1, 1, 8'h25, 2));
    applyStimulus(mkVec(0, 0, 8'h00, 0, 1, 8'h26, 0, 0, 1, 0, 0, 8'h00, 1));
    checkOutput("sqfill3", mkVec(0, 0, 8'h00, 0, 1, 8'h26, 0, 0, 1, 0, 0, 8'h00, 1));
    applyStimulus(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 6, 0, 1, 0, 0, 8'h00, 1));
    checkOutput("sqfill4", mkVec(0, 0, 8'h00, 0, 0, 8'h00, 6, 0, 1, 0, 0, 8'h00, 1));
    applyStimulus(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
    checkOutput("sqfill5", mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));

    // Reset with three entries pending discards them; old tags then miss.
    applyStimulus(mkVec(0, 1, 8'h31, 1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
    checkOutput("rst0", mkVec(0, 1, 8'h31, 1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0));
    applyStimulus(mkVec(0, 1, 8'h32, 2, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
    checkOutput("rst1", mkVec(0, 1, 8'h32, 2, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1));
    applyStimulus(mkVec(0, 1, 8'h33, 3, 1, 8'h31, 0, 0, 1, 1, 0, 8'h00, 2));
    checkOutput("rst2", mkVec(0, 1, 8'h33, 3, 1, 8'h31, 0, 0, 1, 1, 0, 8'h00, 2));
    applyStimulus(mkVec(1, 0, 8'h00, 0, 1, 8'h31, 1, 0, 1, 0, 0, 8'h00, 0));
    checkOutput("rst3", mkVec(1, 0, 8'h00, 0, 1, 8'h31, 1, 0, 1, 0, 0, 8'h00, 0));
    applyStimulus(mkVec(0, 0, 8'h00, 0, 1, 8'h32, 2, 0, 1, 0, 0, 8'h00, 0));
    checkOutput("rst4", mkVec(0, 0, 8'h00, 0, 1, 8'h32, 2, 0, 1, 0, 0, 8'h00, 0));
    applyStimulus(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 3, 0, 1, 0, 0, 8'h00, 0));
    checkOutput("rst5", mkVec(0, 0, 8'h00, 0, 0, 8'h00, 3, 0, 1, 0, 0, 8'h00, 0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
